// File: rtl/data_mem_responder.sv
// Single-port word memory behind a req/ready, ack/err handshake.
// One request is accepted in IDLE. The FSM then spends WAIT cycles in WAIT
// and presents a one-cycle registered response in RESP. Writes commit on the
// edge that ends RESP, so a reset during the transaction discards them.
module data_mem_responder #(
   parameter int DEPTH = 128,
   parameter int WAIT  = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic        ready_o,
   output logic        ack_o,
   output logic [31:0] data_o,
   output logic        err_o
);

   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic        we_q;
   logic        ready_q;
   logic        ack_q;
   logic        err_q;
   logic [31:0] rdata_q;

   // The whole array clears on reset, so it is built from registers rather than block RAM.
   logic [31:0] mem [DEPTH];

   // Response source: the live inputs when a WAIT=0 request is answered straight from IDLE, otherwise the latched copy.
   logic [31:0]     src_addr;
   logic            src_we;
   logic            src_err;
   logic [IDXW-1:0] src_idx;
   logic [31:0]     src_word;

   logic            wr_en;
   logic [IDXW-1:0] wr_idx;

   // Decode the address that the response is about to report on.
   always_comb begin
      src_addr = (state == S_IDLE) ? addr_i : addr_q;
      src_we   = (state == S_IDLE) ? we_i : we_q;
      src_err  = (src_addr[1:0] != 2'b00) ||
                 ({2'b00, src_addr[31:2]} >= 32'(DEPTH));
      src_idx  = src_addr[IDXW+1:2];
      src_word = mem[src_idx];
   end

   // A write commits when RESP ends. err_q holds the error flag for this transaction during RESP.
   assign wr_en  = (state == S_RESP) && we_q && !err_q;
   assign wr_idx = addr_q[IDXW+1:2];

   // Memory array: async clear, and one word is written when a valid write leaves RESP.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_idx] <= data_q;
      end
   end

   // Transaction FSM. The request is latched here and the outputs are registered.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= S_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         ready_q <= 1'b1;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_i) begin
                  addr_q  <= addr_i;
                  data_q  <= data_i;
                  we_q    <= we_i;
                  ready_q <= 1'b0;
                  if (WAIT == 0) begin
                     state   <= S_RESP;
                     ack_q   <= 1'b1;
                     err_q   <= src_err;
                     rdata_q <= (src_err || src_we) ? 32'h0 : src_word;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= 4'(WAIT);
                  end
               end
            end
            S_WAIT: begin
               // The counter reaching zero on this edge moves the FSM into RESP.
               if (cnt <= 4'd1) begin
                  cnt     <= '0;
                  state   <= S_RESP;
                  ack_q   <= 1'b1;
                  err_q   <= src_err;
                  rdata_q <= (src_err || src_we) ? 32'h0 : src_word;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               state   <= S_IDLE;
               ready_q <= 1'b1;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
            default: begin
               state   <= S_IDLE;
               cnt     <= '0;
               ready_q <= 1'b1;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
         endcase
      end
   end

   assign ready_o = ready_q;
   assign ack_o   = ack_q;
   assign data_o  = rdata_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder. Stimulus pushes expected responses
// and a negedge monitor pops and compares them whenever ack_o is high.
// A second instance with WAIT=0 is checked directly.
module tb_data_mem_responder;

   localparam int WAIT_P = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic        ready, ack, err;
   logic [31:0] rdata;

   logic        req0, we0;
   logic [31:0] addr0, wdata0;
   logic        ready0, ack0, err0;
   logic [31:0] rdata0;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   logic prev_ack = 1'b0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder #(.DEPTH(128), .WAIT(WAIT_P)) dut (
      .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
      .data_i(wdata), .ready_o(ready), .ack_o(ack), .data_o(rdata), .err_o(err)
   );

   data_mem_responder #(.DEPTH(128), .WAIT(0)) dut0 (
      .clk_i(clk), .rst_i(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
      .data_i(wdata0), .ready_o(ready0), .ack_o(ack0), .data_o(rdata0), .err_o(err0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop and compare on each ack. Outside the ack cycle, data and err must be zero.
   always @(negedge clk) begin
      exp_t e;
      if (ack === 1'b1) begin
         check("ack_single_cycle", 32'(prev_ack), 32'(0));
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack data=%h err=%b expected no ack (cycle %0d)", rdata, err, cyc);
         end else begin
            e = sb.pop_front();
            check("ack_data", rdata, e.data);
            check("ack_err", 32'(err), 32'(e.err));
            check("ack_cycle", 32'(cyc), 32'(e.cyc));
         end
      end else begin
         check("idle_data", rdata, 32'h0);
         check("idle_err", 32'(err), 32'(0));
      end
      prev_ack = ack;
   end

   // Issue one request on the main instance, starting from a negedge.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input logic exp_e, input bit push);
      int t;
      t = 0;
      while (ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: got ready=%b expected 1 within 50 cycles", ready);
      end
      $display("issue we=%b addr=%h data=%h at cycle %0d", w, a, d, cyc);
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      if (push) sb.push_back('{exp_d, exp_e, cyc + 1 + WAIT_P});
      @(negedge clk);
      req   = 1'b0;
      addr  = 32'hFFFF_FFFF;
      wdata = 32'h5555_5555;
      check("ready_low_after_accept", 32'(ready), 32'(0));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc[$];
      rst_n = 1'b0;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'(1));
      check("rst_ack", 32'(ack), 32'(0));
      check("rst_data", rdata, 32'h0);
      check("rst_err", 32'(err), 32'(0));
      rst_n = 1'b1;

      // Read of address 0 straight after reset.
      issue(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      drain();

      // Write, then read back.
      issue(1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 1'b1);
      drain();

      // Error cases: misaligned and out-of-range writes. Then the last word and the earlier data read back.
      issue(1'b1, 32'h11, 32'hAAAA_AAAA, 32'h0, 1'b1, 1'b1);
      issue(1'b1, 32'h200, 32'hBBBB_BBBB, 32'h0, 1'b1, 1'b1);
      issue(1'b0, 32'h1FC, 32'h0, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 1'b1);
      drain();

      // Hold req high continuously. Accepts must fall every WAIT+2 cycles.
      req = 1'b1; we = 1'b0; addr = 32'h10;
      for (int i = 0; i < 16; i++) begin
         if (ready === 1'b1) begin
            $display("hold-req accept at cycle %0d", cyc);
            acc.push_back(cyc);
            sb.push_back('{32'h1234_5678, 1'b0, cyc + 1 + WAIT_P});
         end
         @(negedge clk);
      end
      req = 1'b0;
      check("hold_accept_count", 32'(acc.size()), 32'(4));
      for (int i = 1; i < acc.size(); i++) begin
         check("hold_accept_period", 32'(acc[i] - acc[i-1]), 32'(WAIT_P + 2));
      end
      drain();

      // Reset during the WAIT state of a write aborts it.
      issue(1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("abort_ready", 32'(ready), 32'(1));
      check("abort_ack", 32'(ack), 32'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      issue(1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1);
      drain();

      // WAIT=0 instance: ack is high in the cycle right after acceptance.
      $display("wait0 write addr=00000004 data=cafef00d at cycle %0d", cyc);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'hCAFE_F00D;
      @(negedge clk);
      req0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
      check("w0_wr_ack", 32'(ack0), 32'(1));
      check("w0_wr_data", rdata0, 32'h0);
      check("w0_wr_err", 32'(err0), 32'(0));
      @(negedge clk);
      check("w0_ack_drop", 32'(ack0), 32'(0));
      check("w0_ready_back", 32'(ready0), 32'(1));
      $display("wait0 read addr=00000004 at cycle %0d", cyc);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
      @(negedge clk);
      req0 = 1'b0;
      check("w0_rd_ack", 32'(ack0), 32'(1));
      check("w0_rd_data", rdata0, 32'hCAFE_F00D);
      check("w0_rd_err", 32'(err0), 32'(0));
      @(negedge clk);
      check("w0_rd_after_data", rdata0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, giving the number of 32-bit memory words.
REQ-002 The block SHALL have parameter WAIT, default 2, giving the wait cycles inserted between request acceptance and response (legal 0..15).
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port req_i, input, 1 bit, the initiator's request valid.
REQ-006 The block SHALL have port we_i, input, 1 bit: 1 means write, 0 means read, qualified by req_i.
REQ-007 The block SHALL have port addr_i, input, 32 bits, the byte address.
REQ-008 The block SHALL have port data_i, input, 32 bits, the write data.
REQ-009 The block SHALL have port ready_o, output, 1 bit, asserted when the block can accept a request.
REQ-010 The block SHALL have port ack_o, output, 1 bit, a one-cycle response strobe.
REQ-011 The block SHALL have port data_o, output, 32 bits, the read data, valid while ack_o=1.
REQ-012 The block SHALL have port err_o, output, 1 bit, the error flag, valid while ack_o=1.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-014 ready_o SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted on the rising edge where req_i=1 and ready_o=1.
REQ-016 At acceptance, addr_i, data_i and we_i SHALL be latched; later input changes SHALL have no effect on the transaction.
REQ-017 On acceptance the FSM SHALL go IDLE->WAIT with the wait counter loaded to WAIT; with WAIT=0 it SHALL go IDLE->RESP directly.
REQ-018 In WAIT the counter SHALL decrement once per cycle, and the FSM SHALL go to RESP on the edge where the counter reaches 0.
REQ-019 ack_o SHALL be 1 for exactly one cycle, in RESP; the FSM SHALL then return to IDLE unconditionally.
REQ-020 Latency SHALL be: acceptance edge E gives ack_o high during the cycle after edge E+WAIT (WAIT=0: the cycle immediately after acceptance).
REQ-021 The word index SHALL be latched addr[31:2]; a request SHALL be in error if addr[1:0]!=0 or the index is >=DEPTH.
REQ-022 A valid read SHALL drive data_o = mem[index] during the ack cycle, with err_o=0.
REQ-023 A valid write SHALL update mem[index] with the latched data on the edge ending the RESP cycle; data_o SHALL be 0 during its ack cycle.
REQ-024 An errored request SHALL give err_o=1 and data_o=0 during the ack cycle, and an errored write SHALL leave memory unmodified.
REQ-025 Outside the ack cycle, data_o and err_o SHALL be 0.
REQ-026 req_i asserted outside IDLE SHALL be ignored (not queued).
REQ-027 A new request SHALL be acceptable on the edge following the ack cycle, giving a back-to-back period of WAIT+2 cycles.
REQ-028 A read of a word written by an earlier completed write SHALL return the new value.

Reset
REQ-029 While rst_i=0 the block SHALL hold the FSM in IDLE, the counter at 0, ready_o=1, ack_o=0, data_o=0, err_o=0, and all memory words at 0, independent of clk_i.
REQ-030 Reset asserted mid-transaction SHALL abort it: no ack, and no memory write.
REQ-031 After rst_i deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-032 Reset, then read addr 0x0 -> ready_o drops, and ack_o pulses during the third cycle after acceptance (WAIT=2) with data_o=0x00000000 and err_o=0.
REQ-033 Write 0x12345678 to 0x10, then read 0x10 -> the read ack shows data_o=0x12345678, and the write ack shows data_o=0.
REQ-034 Write to 0x11 (misaligned) and to 0x200 (index 128, DEPTH=128), then read 0x10 -> err_o=1 on both error acks, and 0x10 still reads 0x12345678.
REQ-035 Hold req_i=1 continuously -> requests are accepted every 4 cycles (WAIT=2), ack_o is never high on two consecutive cycles, and no request is taken while ready_o=0.
REQ-036 Assert rst_i=0 in the WAIT cycle of a write of 0xDEADBEEF to 0x20 -> no ack, and after reset 0x20 reads 0x00000000.
REQ-037 With WAIT=0, issue a read -> ack_o is high during the cycle immediately after acceptance.
